// File: rtl/alu_opcode_pkg.sv
// Shared ALU operation codes and RV32I base opcode constants.
// Pure definitions; no timing.
// No flow control.
package alu_opcode_pkg;

  // ALU operation codes: {funct7[5], funct3} of the matching R-type instruction.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Major opcode of register-register integer operations.
  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  // funct7 values accepted for the base integer set.
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // funct3 values that have an alternate (funct7[5] = 1) form.
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  // R-type instruction word, laid out MSB first to match the encoding.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_word_t;

  // True when funct7/funct3 name an RV32I base R-type operation.
  // Everything else (including the M extension, funct7 = 0000001) is rejected.
  function automatic logic is_legal_r_funct(input logic [6:0] funct7,
                                            input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (funct7 == FUNCT7_BASE) begin
      ok = 1'b1;
    end else if (funct7 == FUNCT7_ALT) begin
      ok = (funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA);
    end
    return ok;
  endfunction

endpackage

// File: rtl/r_type_field_decode.sv
// Combinational R-type field split, ALU op mapping and legality check.
// Latency 0 (purely combinational).
// No flow control; output follows input every cycle.
module r_type_field_decode
  import alu_opcode_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        illegal
);

  rtype_word_t word;
  logic        legal;

  assign word = rtype_word_t'(instruction);

  // Register indices are reported straight from the raw fields, legal or not.
  assign rd  = word.rd;
  assign rs1 = word.rs1;
  assign rs2 = word.rs2;

  // Map legal encodings to {funct7[5], funct3}; anything else degrades to ADD.
  always_comb begin
    legal   = (word.opcode == OPCODE_OP) && is_legal_r_funct(word.funct7, word.funct3);
    alu_op  = ALU_ADD;
    illegal = 1'b1;
    if (legal) begin
      alu_op  = {word.funct7[5], word.funct3};
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/instr_decoder_r.sv
// Registered RV32I R-type decoder: register indices, ALU op code, illegal flag.
// Latency 1 cycle; outputs hold when no instruction is accepted.
// No backpressure; accepts one instruction per cycle.
module instr_decoder_r
  import alu_opcode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  output logic        out_valid,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        illegal
);

  logic [3:0] dec_alu_op;
  logic [4:0] dec_rd;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_illegal;

  r_type_field_decode u_field_decode (
    .instruction (instruction),
    .alu_op      (dec_alu_op),
    .rd          (dec_rd),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .illegal     (dec_illegal)
  );

  // Output stage: reset wins over a valid word; idle cycles keep the last decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_op    <= ALU_ADD;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= instr_valid;
      if (instr_valid) begin
        alu_op  <= dec_alu_op;
        rd      <= dec_rd;
        rs1     <= dec_rs1;
        rs2     <= dec_rs2;
        illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder_r.sv
// Directed self-checking bench for instr_decoder_r.
// Checks each result one cycle after its input edge.
// Inputs driven #1 after the rising edge, outputs sampled at the same point.
module tb_instr_decoder_r;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  instr_decoder_r dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .out_valid   (out_valid),
    .alu_op      (alu_op),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output against hand-computed values.
  task automatic expect_out(input string tag, input logic ov, input logic [3:0] op,
                            input logic [4:0] erd, input logic [4:0] ers1,
                            input logic [4:0] ers2, input logic ill);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".alu_op"},    {28'd0, alu_op},    {28'd0, op});
    chk({tag, ".rd"},        {27'd0, rd},        {27'd0, erd});
    chk({tag, ".rs1"},       {27'd0, rs1},       {27'd0, ers1});
    chk({tag, ".rs2"},       {27'd0, rs2},       {27'd0, ers2});
    chk({tag, ".illegal"},   {31'd0, illegal},   {31'd0, ill});
  endtask

  // Present one input cycle, then step past the edge to where its result shows.
  task automatic cycle(input logic r, input logic v, input logic [31:0] w);
    rst         = r;
    instr_valid = v;
    instruction = w;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] word;
    logic [3:0]  op;
    logic        ill;
  } vec_t;

  vec_t stream[6];
  vec_t bad[3];

  initial begin
    stream[0] = '{"sll", 32'h001111B3, 4'b0001, 1'b0};
    stream[1] = '{"xor", 32'h001141B3, 4'b0100, 1'b0};
    stream[2] = '{"srl", 32'h001151B3, 4'b0101, 1'b0};
    stream[3] = '{"sra", 32'h401151B3, 4'b1101, 1'b0};
    stream[4] = '{"or",  32'h001161B3, 4'b0110, 1'b0};
    stream[5] = '{"and", 32'h001171B3, 4'b0111, 1'b0};
    bad[0]    = '{"addi",    32'h00110193, 4'b0000, 1'b1};
    bad[1]    = '{"alt_xor", 32'h401141B3, 4'b0000, 1'b1};
    bad[2]    = '{"mul",     32'h021101B3, 4'b0000, 1'b1};

    // Reset for two cycles, with a valid word present that must be ignored.
    cycle(1'b1, 1'b1, 32'h001101B3);
    cycle(1'b1, 1'b0, 32'h0);
    expect_out("reset", 1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0);
    expect_out("post_reset", 1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0);

    // add x3,x2,x1 then sub x3,x2,x1.
    cycle(1'b0, 1'b1, 32'h001101B3);
    expect_out("add", 1'b1, 4'b0000, 5'd3, 5'd2, 5'd1, 1'b0);
    cycle(1'b0, 1'b1, 32'h401101B3);
    expect_out("sub", 1'b1, 4'b1000, 5'd3, 5'd2, 5'd1, 1'b0);

    // Back-to-back legal stream.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, stream[i].word);
      expect_out(stream[i].name, 1'b1, stream[i].op, 5'd3, 5'd2, 5'd1, stream[i].ill);
    end

    // Illegal words still report raw register fields.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, bad[i].word);
      expect_out(bad[i].name, 1'b1, bad[i].op, 5'd3, 5'd2, 5'd1, bad[i].ill);
    end

    // add x0,x0,x0: rd = 0 is legal.
    cycle(1'b0, 1'b1, 32'h00000033);
    expect_out("add_x0", 1'b1, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0);

    // sltu x5,x6,x7 = 0x007332B3, then a 2-cycle gap with a live word on the bus.
    cycle(1'b0, 1'b1, 32'h007332B3);
    expect_out("sltu", 1'b1, 4'b0011, 5'd5, 5'd6, 5'd7, 1'b0);
    cycle(1'b0, 1'b0, 32'h401101B3);
    expect_out("gap1", 1'b0, 4'b0011, 5'd5, 5'd6, 5'd7, 1'b0);
    cycle(1'b0, 1'b0, 32'h00110193);
    expect_out("gap2", 1'b0, 4'b0011, 5'd5, 5'd6, 5'd7, 1'b0);
    // slt x9,x10,x11 = 0x00B524B3 resumes the stream.
    cycle(1'b0, 1'b1, 32'h00B524B3);
    expect_out("slt", 1'b1, 4'b0010, 5'd9, 5'd10, 5'd11, 1'b0);

    // Reset coinciding with a valid sub: the sub is discarded.
    cycle(1'b1, 1'b1, 32'h401101B3);
    expect_out("rst_sub", 1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0);
    expect_out("rst_sub_after", 1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
